// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the RV32M multiply path.
// Consumed by mul_ctrl and its bus interface.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam int XLEN = 32;

    // Returns {sign0, sign1}; sign1 marks operand m as signed, sign0 marks r.
    function automatic logic [1:0] mul_sign_f(input mul_op_e op);
        logic [1:0] s;
        s = 2'b00;
        case (op)
            MULH:    s = 2'b11;
            MULHSU:  s = 2'b01;
            default: s = 2'b00;
        endcase
        return s;
    endfunction

    function automatic logic mul_hi_f(input mul_op_e op);
        return (op != MUL);
    endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Execute-side, multiplier-side and writeback-side signals of the multiply controller.
// master = controller view, slave = surrounding pipeline/multiplier view.
interface mul_ctrl_if;
    import muldiv_pkg::*;

    logic        in_valid;
    logic        in_ready;
    mul_op_e     in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        flush;

    logic        mul_go;
    logic        mul_sign0;
    logic        mul_sign1;
    logic [31:0] mul_m;
    logic [31:0] mul_r;
    logic        mul_done;
    logic [63:0] mul_result;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;

    modport master (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, flush,
        input  mul_done, mul_result, out_ready,
        output in_ready, mul_go, mul_sign0, mul_sign1, mul_m, mul_r,
        output out_valid, out_data, out_rd
    );

    modport slave (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, flush,
        output mul_done, mul_result, out_ready,
        input  in_ready, mul_go, mul_sign0, mul_sign1, mul_m, mul_r,
        input  out_valid, out_data, out_rd
    );

endinterface

// File: rtl/mul_ctrl.sv
// Issue/writeback controller between execute and a LATENCY-deep 64-bit multiplier.
// Optional MUL_ZERO_BYPASS_EN: ops with a zero operand skip the multiplier entirely.
module mul_ctrl
    import muldiv_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input logic        clk,
    input logic        reset,
    mul_ctrl_if.master bus
);

    mul_state_e  state_q, state_d;
    mul_op_e     op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] m_q, m_d;
    logic [31:0] r_q, r_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  sign_q, sign_d;
    logic        kill_q, kill_d;
    logic        accept;
    logic        zero_op;

    always_comb begin
        bus.in_ready = ~reset & ~bus.flush &
                       ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
    end

    assign accept = bus.in_valid & bus.in_ready;

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op = (bus.in_rs1 == '0) | (bus.in_rs2 == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        m_d     = m_q;
        r_d     = r_q;
        sign_d  = sign_q;
        data_d  = data_q;
        kill_d  = kill_q;

        case (state_q)
            IDLE: ;
            BUSY: begin
                // go stays high after a flush so the multiplier still wraps to idle.
                if (bus.flush) kill_d = 1'b1;
                if (bus.mul_done) begin
                    kill_d = 1'b0;
                    if (kill_q | bus.flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                        data_d  = mul_hi_f(op_q) ? bus.mul_result[63:32]
                                                 : bus.mul_result[31:0];
                    end
                end
            end
            DONE: begin
                if (bus.flush | bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Accept overrides the DONE exit so back-to-back ops go straight to BUSY.
        if (accept) begin
            op_d   = bus.in_op;
            rd_d   = bus.in_rd;
            m_d    = bus.in_rs1;
            r_d    = bus.in_rs2;
            sign_d = mul_sign_f(bus.in_op);
            if (zero_op) begin
                state_d = DONE;
                data_d  = '0;
            end else begin
                state_d = BUSY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MUL;
            rd_q    <= '0;
            m_q     <= '0;
            r_q     <= '0;
            sign_q  <= '0;
            data_q  <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            m_q     <= m_d;
            r_q     <= r_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
            kill_q  <= kill_d;
        end
    end

    assign bus.mul_go    = (state_q == BUSY);
    assign bus.mul_m     = m_q;
    assign bus.mul_r     = r_q;
    assign bus.mul_sign0 = sign_q[1];
    assign bus.mul_sign1 = sign_q[0];
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = data_q;
    assign bus.out_rd    = rd_q;

`ifndef SYNTHESIS
    int busy_cnt;

    always_ff @(posedge clk) begin
        if (reset || state_q != BUSY) busy_cnt <= 0;
        else                          busy_cnt <= busy_cnt + 1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(bus.mul_done && state_q != BUSY))
                else $error("mul_ctrl: mul_done outside BUSY");
            assert (!(state_q == BUSY && busy_cnt > LATENCY))
                else $error("mul_ctrl: BUSY exceeded LATENCY+1 cycles");
        end
    end
`endif

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl with a behavioural multiplier and RV32M reference.
// Build with MUL_ZERO_BYPASS_EN defined to exercise the zero-operand bypass.
module tb_mul_ctrl;
    import muldiv_pkg::*;

    localparam int LAT = 4;
`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mul_ctrl_if bus ();

    mul_ctrl #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached multiplier: done on the LATENCY-th go cycle after start, counter wraps on done.
    int mcnt;
    logic [63:0] pm, pr;
    always @(posedge clk) begin
        if (reset)           mcnt <= 0;
        else if (bus.mul_go) mcnt <= bus.mul_done ? 0 : mcnt + 1;
    end
    assign bus.mul_done   = bus.mul_go && (mcnt == LAT);
    assign pm             = bus.mul_sign1 ? {{32{bus.mul_m[31]}}, bus.mul_m} : {32'b0, bus.mul_m};
    assign pr             = bus.mul_sign0 ? {{32{bus.mul_r[31]}}, bus.mul_r} : {32'b0, bus.mul_r};
    assign bus.mul_result = pm * pr;

    // Architectural RV32M result.
    function automatic logic [31:0] ref_f(input mul_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            MUL:     p = 64'(ua * ub);
            MULH:    p = 64'(sa * sb);
            MULHSU:  p = 64'(sa * ub);
            default: p = 64'(ua * ub);
        endcase
        return (op == MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [1:0] exp_sign(input mul_op_e op);
        if (op == MULH)   return 2'b11;
        if (op == MULHSU) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input mul_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_rd    = rd;
        #1;
        chk("accept_in_ready", 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_op     = mul_op_e'($urandom_range(0, 3));
        bus.in_rs1    = $urandom;
        bus.in_rs2    = $urandom;
        bus.in_rd     = 5'($urandom);
        #1;
    endtask

    task automatic wait_result(input mul_op_e op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int stall);
        logic [31:0] exp_d;
        int exp_lat, n;
        bit byp;
        byp     = BYPASS && (a == 0 || b == 0);
        exp_d   = ref_f(op, a, b);
        exp_lat = byp ? 1 : LAT + 2;
        n = 1;
        while (!bus.out_valid && n < 3 * LAT + 10) begin
            if (byp) begin
                chk("bypass_no_go", 64'(bus.mul_go), 64'(0));
            end else begin
                chk("busy_go", 64'(bus.mul_go), 64'(1));
                chk("busy_m", 64'(bus.mul_m), 64'(a));
                chk("busy_r", 64'(bus.mul_r), 64'(b));
                chk("busy_sign", 64'({bus.mul_sign0, bus.mul_sign1}), 64'(exp_sign(op)));
            end
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        chk("out_valid", 64'(bus.out_valid), 64'(1));
        chk("out_data", 64'(bus.out_data), 64'(exp_d));
        chk("out_rd", 64'(bus.out_rd), 64'(rd));
        chk("done_go_low", 64'(bus.mul_go), 64'(0));
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid", 64'(bus.out_valid), 64'(1));
            chk("stall_data", 64'(bus.out_data), 64'(exp_d));
            chk("stall_rd", 64'(bus.out_rd), 64'(rd));
            chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
        end
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk("retire_valid", 64'(bus.out_valid), 64'(0));
        chk("retire_in_ready", 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        mul_op_e op;
        logic [31:0] a, b;
        logic [4:0] rd;
        bit done_seen, pending;
        int n;

        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op     = MUL;
        bus.in_rs1    = 32'h5;
        bus.in_rs2    = 32'h6;
        bus.in_rd     = 5'd1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state, with an op offered during reset
        tick(); tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_go", 64'(bus.mul_go), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_out_rd", 64'(bus.out_rd), 64'(0));
        chk("rst_m", 64'(bus.mul_m), 64'(0));
        chk("rst_r", 64'(bus.mul_r), 64'(0));
        chk("rst_sign", 64'({bus.mul_sign0, bus.mul_sign1}), 64'(0));
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        tick();
        chk("idle_in_ready", 64'(bus.in_ready), 64'(1));

        // Directed ops
        issue(MUL, 32'hFFFF_FFFF, 32'h2, 5'd5);
        wait_result(MUL, 32'hFFFF_FFFF, 32'h2, 5'd5, 0);
        retire();
        issue(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        wait_result(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
        retire();
        issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        wait_result(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
        retire();
        issue(MULHSU, 32'hFFFF_FFFF, 32'h2, 5'd8);
        wait_result(MULHSU, 32'hFFFF_FFFF, 32'h2, 5'd8, 0);
        retire();
        issue(MULHSU, 32'h2, 32'hFFFF_FFFF, 5'd9);
        wait_result(MULHSU, 32'h2, 32'hFFFF_FFFF, 5'd9, 0);
        retire();

        // Flush in the second BUSY cycle
        issue(MULH, 32'h8000_0000, 32'h7, 5'd10);
        tick();
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        chk("flush_busy_in_ready", 64'(bus.in_ready), 64'(0));
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        done_seen = 1'b0;
        n = 0;
        while (!done_seen && n < LAT + 4) begin
            chk("flush_go_held", 64'(bus.mul_go), 64'(1));
            chk("flush_no_valid", 64'(bus.out_valid), 64'(0));
            if (bus.mul_done) done_seen = 1'b1;
            tick();
            n++;
        end
        chk("flush_done_seen", 64'(done_seen), 64'(1));
        for (int i = 0; i < 3; i++) begin
            chk("flush_idle_valid", 64'(bus.out_valid), 64'(0));
            chk("flush_idle_go", 64'(bus.mul_go), 64'(0));
            tick();
        end
        chk("flush_idle_ready", 64'(bus.in_ready), 64'(1));
        issue(MUL, 32'd3, 32'd7, 5'd11);
        wait_result(MUL, 32'd3, 32'd7, 5'd11, 0);
        retire();

        // Writeback stall, then back-to-back accept
        issue(MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12);
        wait_result(MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 5);
        bus.out_ready = 1'b1;
        issue(MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd13);
        chk("b2b_valid_low", 64'(bus.out_valid), 64'(0));
        wait_result(MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd13, 0);

        // Flush in DONE with out_ready=1 and a new op offered
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        #1;
        chk("flush_done_in_ready", 64'(bus.in_ready), 64'(0));
        tick();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        #1;
        chk("flush_done_valid", 64'(bus.out_valid), 64'(0));
        chk("flush_done_go", 64'(bus.mul_go), 64'(0));
        chk("flush_done_ready", 64'(bus.in_ready), 64'(1));

        // Flush in IDLE blocks accept
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        chk("flush_idle_in_ready", 64'(bus.in_ready), 64'(0));
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_idle_no_go", 64'(bus.mul_go), 64'(0));

        // Zero operand (bypass when enabled)
        issue(MULH, 32'h0, 32'h1234, 5'd14);
        wait_result(MULH, 32'h0, 32'h1234, 5'd14, 0);
        retire();

        // Reset mid-operation
        issue(MUL, 32'd5, 32'd6, 5'd15);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("midrst_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_go", 64'(bus.mul_go), 64'(0));
        chk("midrst_in_ready", 64'(bus.in_ready), 64'(0));
        reset = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            chk("postrst_valid", 64'(bus.out_valid), 64'(0));
        end
        chk("postrst_ready", 64'(bus.in_ready), 64'(1));

        // Randomized ops with random stalls and back-to-back issue
        pending = 1'b0;
        for (int i = 0; i < 40; i++) begin
            op = mul_op_e'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h0;
            if ($urandom_range(0, 5) == 0) b = 32'h0;
            rd = 5'($urandom);
            if (pending) begin
                if ($urandom_range(0, 1) == 1) bus.out_ready = 1'b1;
                else retire();
            end
            issue(op, a, b, rd);
            wait_result(op, a, b, rd, $urandom_range(0, 2));
            pending = 1'b1;
        end
        retire();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
Issue/writeback controller for the RV32M multiply ops (MUL, MULH, MULHSU, MULHU), placed between the execute stage and the 64-bit multiplier unit. It accepts one op per transaction with a valid/ready handshake. It drives the multiplier's go/sign/operand inputs and waits for done. It then selects the low or high word and presents it to writeback with a valid/ready handshake. It supports pipeline flush.

Parameters:
LATENCY, 4, multiplier pipeline depth; must equal the attached multiplier's setting; 0 means done is combinational with go.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  op available from execute
in_ready  out  1  controller can accept op
in_op  in  2  mul_op_e: MUL=0, MULH=1, MULHSU=2, MULHU=3
in_rs1  in  32  multiplicand
in_rs2  in  32  multiplier
in_rd  in  5  destination register tag
flush  in  1  kill current and in-flight op
mul_go  out  1  multiplier advance/start
mul_sign0  out  1  multiplier sign control 0
mul_sign1  out  1  multiplier sign control 1
mul_m  out  32  multiplier operand m
mul_r  out  32  multiplier operand r
mul_done  in  1  multiplier result valid
mul_result  in  64  multiplier product
out_valid  out  1  result valid to writeback
out_ready  in  1  writeback accepts
out_data  out  32  selected result word
out_rd  out  5  destination tag

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, out_valid=0, mul_go=0, out_data=0, out_rd=0, operand/sign registers 0. in_ready=0 while reset is high.
- States: IDLE, BUSY, DONE.
- in_ready = (IDLE | (DONE & out_ready)) & ~flush.
- Accept (in_valid & in_ready): on the accept edge, register rs1→mul_m, rs2→mul_r, op, and rd; enter BUSY.
- Sign mapping {sign0,sign1}: MUL=00; MULH=11; MULHSU=01 (m signed, r unsigned); MULHU=00.
- BUSY:
  - mul_go=1 every cycle.
  - mul_m, mul_r and the signs are held stable from the first BUSY cycle through the done cycle.
  - On the edge where mul_go & mul_done: capture result (MUL → mul_result[31:0], others → mul_result[63:32]), deassert go, enter DONE.
  - go is held through the done cycle so the multiplier's internal state wraps back to idle.
- DONE:
  - out_valid=1; out_data and out_rd are stable until the handshake.
  - out_ready & ~in_valid → IDLE.
  - out_ready & in_valid → accept the new op and go directly to BUSY (back-to-back).
- Latency: op accepted on the edge ending cycle T; out_valid is first high in cycle T+LATENCY+2 (6 cycles for the default). LATENCY=0 gives T+2.
- Flush:
  - In IDLE: no accept.
  - In BUSY: set a kill flag but keep go high until done, keeping the multiplier in sync. On done, discard the result and go to IDLE; out_valid is never asserted.
  - In DONE: out_valid drops the next cycle and the state goes to IDLE; the result is discarded even if out_ready=1 in the same cycle.
  - The kill flag clears on leaving BUSY.
- Reset mid-operation: the parent resets controller and multiplier together; the controller returns to IDLE with no output.
- Assertions (sim only):
  - mul_done never arrives outside BUSY.
  - BUSY never exceeds LATENCY+1 cycles.

Optional Feature:
MUL_ZERO_BYPASS_EN.
- With it: on accept, if rs1==0 or rs2==0, skip BUSY and go straight to DONE with out_data=0 (latency T+1). mul_go is never asserted for that op. Flush rules are the same as for DONE.
- Without it: all ops go through BUSY.

Decomposition:
- muldiv_pkg contains:
  - mul_op_e enum.
  - mul_sign_f function mapping op → {sign0,sign1}.
  - mul_hi_f function returning whether op selects the high word.
- No sub-module. The multiplier is a peer instance wired by the parent.

Test Plan:
- MUL rs1=0xFFFFFFFF, rs2=2, rd=5 → out_data=0xFFFFFFFE, out_rd=5, out_valid at accept+6.
- MULH rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE.
- MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF. MULHSU rs1=2, rs2=0xFFFFFFFF → 0x00000001.
- Flush in the 2nd BUSY cycle, then MUL 3*7 → no out_valid for the first op; second op gives 21; mul_go held until mul_done.
- out_ready=0 for 5 cycles in DONE → out_valid/out_data stable, in_ready=0. Then out_ready=1 with in_valid=1 → back-to-back accept, next result correct.
- With MUL_ZERO_BYPASS_EN: MULH rs1=0, rs2=0x1234 → out_data=0 at accept+1, mul_go never high.
